mem_port_arbiter: RTL and testbench

//  Shares the single-port program/data memory between two requesters: the

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared single-port memory. The CPU datapath
// normally wins; the debug reader is guaranteed a slot after STARVE_MAX
// consecutive CPU grants made while it was waiting. One transaction is in
// flight at a time: IDLE -> ISSUE -> (WAIT x RD_LAT for reads) -> IDLE.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  // CPU datapath port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Debug reader port (read-only)
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  // Memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned WaitW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q,      state_d;
  logic                owner_q,      owner_d;      // 0 = CPU, 1 = debug
  logic                we_q,         we_d;
  logic [WaitW-1:0]    wait_cnt_q,   wait_cnt_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic                mem_re_q,     mem_re_d;
  logic                mem_we_q,     mem_we_d;
  logic                cpu_gnt_q,    cpu_gnt_d;
  logic                dbg_gnt_q,    dbg_gnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q,  dbg_rdata_d;

  logic dbg_wins;
  logic starved;

  assign starved  = (starve_cnt_q == StarveW'(STARVE_MAX));
  assign dbg_wins = dbg_req && (!cpu_req || starved);

  // Next-state, arbitration and strobe sequencing; all outputs are registered.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // Strobes and pulses default low so they last exactly one cycle.
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_gnt_d    = 1'b0;
    dbg_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;

    // No pending debug request means nobody is being starved.
    if (!dbg_req) begin
      starve_cnt_d = '0;
    end

    case (state_q)
      StIdle: begin
        if (cpu_req || dbg_req) begin
          state_d = StIssue;
          if (dbg_wins) begin
            owner_d      = 1'b1;
            we_d         = 1'b0;
            mem_addr_d   = dbg_addr;
            mem_re_d     = 1'b1;
            dbg_gnt_d    = 1'b1;
            starve_cnt_d = '0;
          end else begin
            owner_d     = 1'b0;
            we_d        = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_re_d    = !cpu_we;
            mem_we_d    = cpu_we;
            cpu_gnt_d   = 1'b1;
            if (dbg_req && !starved) begin
              starve_cnt_d = starve_cnt_q + 1'b1;
            end
          end
        end
      end

      StIssue: begin
        wait_cnt_d = '0;
        state_d    = we_q ? StIdle : StWait;
      end

      StWait: begin
        if (wait_cnt_q == WaitW'(RD_LAT - 1)) begin
          state_d = StIdle;
          if (owner_q) begin
            dbg_rdata_d  = mem_rdata;
            dbg_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = mem_rdata;
            cpu_rvalid_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_re     = mem_re_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance A uses RD_LAT=1, instance B
// uses RD_LAT=3. Stimulus pushes expected responses; monitors pop and compare.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Instance A (RD_LAT = 1)
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we, busy;
  logic [DW-1:0] mem_wdata, mem_rdata;

  // Instance B (RD_LAT = 3)
  logic          cpu_req_b, cpu_we_b, cpu_gnt_b, cpu_rvalid_b;
  logic [AW-1:0] cpu_addr_b;
  logic [DW-1:0] cpu_wdata_b, cpu_rdata_b;
  logic          dbg_req_b, dbg_gnt_b, dbg_rvalid_b;
  logic [AW-1:0] dbg_addr_b;
  logic [DW-1:0] dbg_rdata_b;
  logic [AW-1:0] mem_addr_b;
  logic          mem_re_b, mem_we_b, busy_b;
  logic [DW-1:0] mem_wdata_b, mem_rdata_b;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(8)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(8)) u_dut_b (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_gnt(cpu_gnt_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b),
    .dbg_req(dbg_req_b), .dbg_addr(dbg_addr_b), .dbg_gnt(dbg_gnt_b),
    .dbg_rvalid(dbg_rvalid_b), .dbg_rdata(dbg_rdata_b), .mem_addr(mem_addr_b),
    .mem_re(mem_re_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  // Memory models: read data valid RD_LAT cycles after the mem_re cycle,
  // DEAD otherwise so a mistimed capture is visible.
  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] pipe_b0, pipe_b1;

  always @(posedge clock) begin
    if (mem_we) mem_a[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? mem_a[mem_addr] : 16'hDEAD;
  end

  always @(posedge clock) begin
    pipe_b0     <= mem_re_b ? mem_b[mem_addr_b] : 16'hDEAD;
    pipe_b1     <= pipe_b0;
    mem_rdata_b <= pipe_b1;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]    cpu_q[$];
  logic [DW-1:0]    dbg_q[$];
  logic [DW-1:0]    dbgb_q[$];
  logic [AW+DW-1:0] wr_q[$];
  bit               gnt_q[$];      // expected grant owner: 0 = CPU, 1 = debug
  int               gnt_cyc_q[$];  // cycle stamps of CPU grants
  int               last_cpu_gnt = 0;
  int               last_dbg_gnt = 0;
  int               last_b_gnt = 0;
  bit               chk_busy = 1'b0;
  bit               owner;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance A
  always @(negedge clock) begin
    if (reset_n) begin
      if (cpu_gnt || dbg_gnt) begin
        chk("gnt_exclusive", 64'(cpu_gnt & dbg_gnt), 64'd0);
        if (gnt_q.size() == 0) begin
          chk("gnt_unexpected", 64'({cpu_gnt, dbg_gnt}), 64'd0);
        end else begin
          owner = gnt_q.pop_front();
          chk("gnt_owner", 64'(dbg_gnt), 64'(owner));
        end
        if (cpu_gnt) begin
          last_cpu_gnt = cyc;
          gnt_cyc_q.push_back(cyc);
        end
        if (dbg_gnt) last_dbg_gnt = cyc;
      end
      if (cpu_rvalid || dbg_rvalid) chk("rvalid_exclusive", 64'(cpu_rvalid & dbg_rvalid), 64'd0);
      if (cpu_rvalid) begin
        chk("cpu_rvalid_latency", 64'(cyc - last_cpu_gnt), 64'd2);
        if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 64'd1, 64'd0);
        else chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
      end
      if (dbg_rvalid) begin
        chk("dbg_rvalid_latency", 64'(cyc - last_dbg_gnt), 64'd2);
        if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 64'd1, 64'd0);
        else chk("dbg_rdata", 64'(dbg_rdata), 64'(dbg_q.pop_front()));
      end
      if (mem_re || mem_we) chk("strobe_exclusive", 64'(mem_re & mem_we), 64'd0);
      if (mem_we) begin
        if (wr_q.size() == 0) chk("mem_we_unexpected", 64'd1, 64'd0);
        else chk("mem_write", 64'({mem_addr, mem_wdata}), 64'(wr_q.pop_front()));
      end
      if (chk_busy) chk("busy_vs_rvalid", 64'(busy), 64'(!cpu_rvalid));
    end
  end

  // Monitor for instance B (debug-only traffic)
  always @(negedge clock) begin
    if (reset_n) begin
      if (dbg_gnt_b) begin
        last_b_gnt = cyc;
        chk("b_busy_at_gnt", 64'(busy_b), 64'd1);
      end
      if (cpu_gnt_b || cpu_rvalid_b || mem_we_b)
        chk("b_cpu_side_unexpected", 64'({cpu_gnt_b, cpu_rvalid_b, mem_we_b}), 64'd0);
      if (dbg_rvalid_b) begin
        chk("b_dbg_rvalid_latency", 64'(cyc - last_b_gnt), 64'd4);
        if (dbgb_q.size() == 0) chk("b_dbg_rvalid_unexpected", 64'd1, 64'd0);
        else chk("b_dbg_rdata", 64'(dbg_rdata_b), 64'(dbgb_q.pop_front()));
      end
    end
  end

  task automatic cpu_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp, input bit expect_rd, input bit push_gnt,
                         output int lat);
    if (push_gnt) gnt_q.push_back(1'b0);
    if (we) wr_q.push_back({a, d});
    else if (expect_rd) cpu_q.push_back(exp);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!cpu_gnt && lat < 200);
    if (!cpu_gnt) chk("cpu_gnt_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #2 cpu_req = 1'b0;
  endtask

  task automatic dbg_txn(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input bit push_gnt, output int lat);
    if (push_gnt) gnt_q.push_back(1'b1);
    dbg_q.push_back(exp);
    dbg_addr = a; dbg_req = 1'b1;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!dbg_gnt && lat < 200);
    if (!dbg_gnt) chk("dbg_gnt_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #2 dbg_req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((cpu_q.size() + dbg_q.size() + wr_q.size() + dbgb_q.size()) != 0 && t < 100) begin
      @(posedge clock);
      t++;
    end
    if (t >= 100) chk("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clock);
    #2;
  endtask

  function automatic logic [63:0] all_outs_a();
    return 64'({cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
                mem_addr, mem_re, mem_we, mem_wdata, busy});
  endfunction

  logic [AW-1:0] t4_addr [4] = '{6'h01, 6'h02, 6'h03, 6'h04};
  logic [DW-1:0] t4_data [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

  initial begin
    int lat, l1, l2, t;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 16'hA000 + 16'(i);
      mem_b[i] = 16'hB000 + 16'(i);
    end
    mem_a[5]  = 16'hBEEF;
    mem_b[16] = 16'h00A5;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_addr = '0;
    cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = '0; cpu_wdata_b = '0;
    dbg_req_b = 0; dbg_addr_b = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1 chk("reset_outputs", all_outs_a(), 64'd0);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("idle_outputs", all_outs_a(), 64'd0);
    @(posedge clock);
    #2;

    // 1: CPU read of 05
    cpu_txn(1'b0, 6'h05, 16'h0, 16'hBEEF, 1'b1, 1'b1, lat);
    chk("t1_gnt_one_cycle_after_req_edge", 64'(lat), 64'd2);
    drain();
    chk("t1_cpu_rdata_held", 64'(cpu_rdata), 64'hBEEF);
    chk("t1_dbg_quiet", 64'({dbg_rdata, dbg_gnt, dbg_rvalid}), 64'd0);

    // 2: CPU write 3F <= 1234, then debug read-back
    cpu_txn(1'b1, 6'h3F, 16'h1234, 16'h0, 1'b0, 1'b1, lat);
    drain();
    chk("t2_cpu_rdata_unchanged", 64'(cpu_rdata), 64'hBEEF);
    dbg_txn(6'h3F, 16'h1234, 1'b1, lat);
    drain();
    chk("t2_dbg_rdata_held", 64'(dbg_rdata), 64'h1234);

    // 4: back-to-back CPU reads, grants every 3 cycles
    gnt_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_txn(1'b0, t4_addr[i], 16'h0, t4_data[i], 1'b1, 1'b1, lat);
      if (i == 0) chk_busy = 1'b1;
    end
    @(posedge clock);
    @(posedge clock);
    #1 chk_busy = 1'b0;
    drain();
    chk("t4_grant_count", 64'(gnt_cyc_q.size()), 64'd4);
    if (gnt_cyc_q.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("t4_grant_spacing", 64'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 64'd3);

    // 3: both requesters held from reset -> 8 CPU, 1 debug, 8 CPU, 1 debug, 2 CPU
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (8) gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
    end
    repeat (2) gnt_q.push_back(1'b0);
    fork
      begin
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
      end
      begin
        for (int i = 0; i < 18; i++) cpu_txn(1'b0, 6'h05, 16'h0, 16'hBEEF, 1'b1, 1'b0, l1);
      end
      begin
        dbg_txn(6'h3F, 16'h1234, 1'b0, l2);
        dbg_txn(6'h10, 16'hA010, 1'b0, l2);
      end
    join
    drain();
    chk("t3_grants_consumed", 64'(gnt_q.size()), 64'd0);

    // 5: reset during WAIT aborts the read
    cpu_txn(1'b0, 6'h05, 16'h0, 16'hBEEF, 1'b0, 1'b1, lat);
    #1 reset_n = 1'b0;
    #1 chk("t5_outputs_zero_in_reset", all_outs_a(), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #2 chk("t5_no_rvalid_after_abort", 64'(cpu_rdata), 64'd0);
    cpu_txn(1'b0, 6'h05, 16'h0, 16'hBEEF, 1'b1, 1'b1, lat);
    drain();

    // 6: RD_LAT=3 instance, debug read of 10
    dbgb_q.push_back(16'h00A5);
    dbg_addr_b = 6'h10;
    dbg_req_b  = 1'b1;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!dbg_gnt_b && t < 50);
    if (!dbg_gnt_b) chk("b_dbg_gnt_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #2 dbg_req_b = 1'b0;
    drain();
    chk("t6_dbg_rdata_held", 64'(dbg_rdata_b), 64'h00A5);
    chk("t6_b_cpu_side_quiet", 64'({cpu_rdata_b, mem_wdata_b, mem_we_b}), 64'd0);

    chk("end_queues_empty",
        64'(cpu_q.size() + dbg_q.size() + wr_q.size() + gnt_q.size() + dbgb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
